// File: rtl/lsq_pipe.sv
// In-order load/store queue with split request/response memory handshake.
// Optional misalignment trapping is enabled by defining LSQ_MISALIGN_EN.
module lsq_pipe #(
  parameter int DEPTH    = 8,
  parameter int ROB_BITS = 4,
  parameter int WB_PORTS = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [3:0]                   in_type,
  input  logic [ROB_BITS-1:0]          in_rob,
  input  logic [31:0]                  in_r1,
  input  logic [31:0]                  in_r2,
  input  logic [ROB_BITS-1:0]          in_dep1,
  input  logic [ROB_BITS-1:0]          in_dep2,
  input  logic                         in_has_dep1,
  input  logic                         in_has_dep2,
  input  logic [11:0]                  in_offset,
  output logic                         full,
  input  logic                         cm_valid,
  input  logic [ROB_BITS-1:0]          cm_rob,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*ROB_BITS-1:0] wb_idx,
  input  logic [WB_PORTS*32-1:0]       wb_value,
  output logic                         out_valid,
  output logic [ROB_BITS-1:0]          out_rob,
  output logic [31:0]                  out_value,
  output logic                         out_exc,
  output logic                         st_done,
  output logic                         mem_req_valid,
  output logic                         mem_req_wr,
  output logic [2:0]                   mem_req_len,
  output logic [31:0]                  mem_req_addr,
  output logic [31:0]                  mem_req_data,
  input  logic                         mem_req_ready,
  input  logic                         mem_resp_valid,
  input  logic [31:0]                  mem_resp_data
);

  localparam int PTR = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef struct packed {
    logic                is_store;
    logic [2:0]          funct3;
    logic [ROB_BITS-1:0] rob;
    logic [31:0]         r1;
    logic [31:0]         r2;
    logic [ROB_BITS-1:0] dep1;
    logic [ROB_BITS-1:0] dep2;
    logic                has_dep1;
    logic                has_dep2;
    logic [11:0]         offset;
  } entry_t;

  entry_t           ent [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [PTR-1:0]   head, tail, head_nxt, tail_nxt;
  logic [PTR:0]     count, count_nxt;
  logic [1:0]       state, state_nxt;

  // Lowest channel wins: scan downward so the last hit is the smallest k.
  function automatic logic [32:0] wb_lookup(input logic [ROB_BITS-1:0] tag);
    logic [32:0] r;
    r = '0;
    for (int k = WB_PORTS - 1; k >= 0; k--)
      if (wb_valid[k] && wb_idx[k*ROB_BITS +: ROB_BITS] == tag)
        r = {1'b1, wb_value[k*32 +: 32]};
    return r;
  endfunction

  entry_t      he, new_ent;
  logic [31:0] head_addr;
  logic        eligible, head_mis, accept, exc_pop, resp_pop;
  logic [32:0] wk1 [DEPTH];
  logic [32:0] wk2 [DEPTH];
  logic [32:0] pk1, pk2;

  assign he        = ent[head];
  assign head_addr = he.r1 + {{20{he.offset[11]}}, he.offset};
  assign eligible  = busy[head] && !he.has_dep1 && !he.has_dep2 &&
                     (!he.is_store || (cm_valid && cm_rob == he.rob));

`ifdef LSQ_MISALIGN_EN
  assign head_mis = (he.funct3[1:0] == 2'b01 && head_addr[0]) ||
                    (he.funct3[1:0] == 2'b10 && head_addr[1:0] != 2'b00);
`else
  assign head_mis = 1'b0;
`endif

  assign mem_req_valid = rdy_in && state == S_IDLE && eligible && !head_mis;
  assign mem_req_wr    = he.is_store;
  assign mem_req_len   = he.funct3;
  assign mem_req_addr  = head_addr;
  assign mem_req_data  = he.r2;

  assign accept   = mem_req_valid && mem_req_ready;
  assign exc_pop  = rdy_in && state == S_IDLE && eligible && head_mis;
  assign resp_pop = state == S_WAIT && mem_resp_valid;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wk1[i] = wb_lookup(ent[i].dep1);
      wk2[i] = wb_lookup(ent[i].dep2);
    end
    pk1 = wb_lookup(in_dep1);
    pk2 = wb_lookup(in_dep2);
    new_ent.is_store = in_type[3];
    new_ent.funct3   = in_type[2:0];
    new_ent.rob      = in_rob;
    new_ent.dep1     = in_dep1;
    new_ent.dep2     = in_dep2;
    new_ent.offset   = in_offset;
    new_ent.has_dep1 = in_has_dep1 && !pk1[32];
    new_ent.has_dep2 = in_has_dep2 && !pk2[32];
    new_ent.r1       = (in_has_dep1 && pk1[32]) ? pk1[31:0] : in_r1;
    new_ent.r2       = (in_has_dep2 && pk2[32]) ? pk2[31:0] : in_r2;
  end

  logic pop, push, keep_head, clear_all, ld_done, st_pulse, exc_done;

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = count;
    pop       = 1'b0;
    push      = 1'b0;
    keep_head = 1'b0;
    clear_all = 1'b0;
    ld_done   = 1'b0;
    st_pulse  = 1'b0;
    exc_done  = 1'b0;
    if (flush) begin
      clear_all = 1'b1;
      head_nxt  = '0;
      tail_nxt  = '0;
      count_nxt = '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (he.is_store) keep_head = 1'b1;
            else             state_nxt = S_DRAIN;
          end
        end
        S_WAIT: begin
          if (he.is_store) begin
            if (mem_resp_valid) begin
              st_pulse  = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              keep_head = 1'b1;
            end
          end else begin
            state_nxt = mem_resp_valid ? S_IDLE : S_DRAIN;
          end
        end
        default: if (mem_resp_valid) state_nxt = S_IDLE;
      endcase
      // A committed store already handed to memory survives the flush.
      if (keep_head) begin
        clear_all = 1'b0;
        head_nxt  = head;
        tail_nxt  = head + PTR'(1);
        count_nxt = (PTR+1)'(1);
        state_nxt = S_WAIT;
      end
    end else begin
      ld_done  = resp_pop && !he.is_store;
      st_pulse = resp_pop && he.is_store;
      exc_done = exc_pop;
      pop      = resp_pop || exc_pop;
      push     = in_valid && (!full || pop);
      case (state)
        S_IDLE:  if (accept) state_nxt = S_WAIT;
        S_WAIT:  if (mem_resp_valid) state_nxt = S_IDLE;
        default: if (mem_resp_valid) state_nxt = S_IDLE;
      endcase
      head_nxt  = head + PTR'(pop);
      tail_nxt  = tail + PTR'(push);
      count_nxt = count + (PTR+1)'(push) - (PTR+1)'(pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      full      <= 1'b0;
      busy      <= '0;
      out_valid <= 1'b0;
      out_exc   <= 1'b0;
      out_rob   <= '0;
      out_value <= '0;
      st_done   <= 1'b0;
    end else if (rdy_in) begin
      state     <= state_nxt;
      head      <= head_nxt;
      tail      <= tail_nxt;
      count     <= count_nxt;
      full      <= count_nxt == (PTR+1)'(DEPTH);
      out_valid <= ld_done || exc_done;
      out_exc   <= exc_done;
      st_done   <= st_pulse;
      if (ld_done) begin
        out_rob   <= he.rob;
        out_value <= mem_resp_data;
      end else if (exc_done) begin
        out_rob   <= he.rob;
        out_value <= head_addr;
      end
      if (clear_all) begin
        busy <= '0;
      end else if (keep_head) begin
        busy       <= '0;
        busy[head] <= 1'b1;
      end else begin
        if (pop)  busy[head] <= 1'b0;
        if (push) busy[tail] <= 1'b1;
      end
    end
  end

  // NOTE: entry payload has no reset; busy alone decides whether an entry is live.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && tail == PTR'(i)) begin
          ent[i] <= new_ent;
        end else if (busy[i]) begin
          if (ent[i].has_dep1 && wk1[i][32]) begin
            ent[i].r1       <= wk1[i][31:0];
            ent[i].has_dep1 <= 1'b0;
          end
          if (ent[i].has_dep2 && wk2[i][32]) begin
            ent[i].r2       <= wk2[i][31:0];
            ent[i].has_dep2 <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lsq_pipe.sv
// Directed bench for lsq_pipe: table of single loads plus hand-written
// sequences for commit gating, full, wake-up, flush and stall corners.
module tb_lsq_pipe;

  localparam int DEPTH = 8;
  localparam int RB    = 4;
  localparam int WB    = 2;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, flush, in_valid;
  logic [3:0]    in_type;
  logic [RB-1:0] in_rob, in_dep1, in_dep2, cm_rob;
  logic [31:0]   in_r1, in_r2;
  logic          in_has_dep1, in_has_dep2, cm_valid;
  logic [11:0]   in_offset;
  logic          full;
  logic [WB-1:0] wb_valid;
  logic [WB*RB-1:0] wb_idx;
  logic [WB*32-1:0] wb_value;
  logic          out_valid, out_exc, st_done;
  logic [RB-1:0] out_rob;
  logic [31:0]   out_value;
  logic          mem_req_valid, mem_req_wr, mem_req_ready, mem_resp_valid;
  logic [2:0]    mem_req_len;
  logic [31:0]   mem_req_addr, mem_req_data, mem_resp_data;

  lsq_pipe #(.DEPTH(DEPTH), .ROB_BITS(RB), .WB_PORTS(WB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .in_valid(in_valid), .in_type(in_type), .in_rob(in_rob),
    .in_r1(in_r1), .in_r2(in_r2), .in_dep1(in_dep1), .in_dep2(in_dep2),
    .in_has_dep1(in_has_dep1), .in_has_dep2(in_has_dep2), .in_offset(in_offset),
    .full(full), .cm_valid(cm_valid), .cm_rob(cm_rob),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value),
    .out_valid(out_valid), .out_rob(out_rob), .out_value(out_value), .out_exc(out_exc),
    .st_done(st_done), .mem_req_valid(mem_req_valid), .mem_req_wr(mem_req_wr),
    .mem_req_len(mem_req_len), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
  );

  always #5 clk_in = ~clk_in;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic push(input logic [3:0] typ, input logic [RB-1:0] rob, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [11:0] off,
                      input logic hd1, input logic [RB-1:0] d1);
    in_valid = 1'b1; in_type = typ; in_rob = rob; in_r1 = r1; in_r2 = r2;
    in_offset = off; in_has_dep1 = hd1; in_dep1 = d1;
    step();
    in_valid = 1'b0; in_has_dep1 = 1'b0;
  endtask

  task automatic complete(input string name, input logic [31:0] data);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = data;
    step();
    mem_resp_valid = 1'b0;
    check({name, "_out_valid"}, 32'(out_valid), 32'd1);
    check({name, "_out_value"}, out_value, data);
  endtask

  typedef struct {
    logic [3:0]  typ;
    logic [RB-1:0] rob;
    logic [31:0] r1;
    logic [11:0] off;
    logic [31:0] resp;
    logic [31:0] exp_addr;
    logic [2:0]  exp_len;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'h2, 4'd1, 32'h0000_0100, 12'h004, 32'hDEAD_BEEF, 32'h0000_0104, 3'd2};
    vecs[1] = '{4'h0, 4'd2, 32'h0000_1000, 12'hFFF, 32'hFFFF_FF80, 32'h0000_0FFF, 3'd0};
    vecs[2] = '{4'h5, 4'd3, 32'hFFFF_FFFE, 12'h004, 32'h0000_BEEF, 32'h0000_0002, 3'd5};
    vecs[3] = '{4'h4, 4'd4, 32'h0000_2000, 12'h7FF, 32'h0000_00AB, 32'h0000_27FF, 3'd4};
    vecs[4] = '{4'h2, 4'd5, 32'h0000_0008, 12'hFF8, 32'h1234_5678, 32'h0000_0000, 3'd2};

    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; in_valid = 1'b0; in_type = '0;
    in_rob = '0; in_r1 = '0; in_r2 = '0; in_dep1 = '0; in_dep2 = '0;
    in_has_dep1 = 1'b0; in_has_dep2 = 1'b0; in_offset = '0;
    cm_valid = 1'b0; cm_rob = '0; wb_valid = '0; wb_idx = '0; wb_value = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    step(); step();
    rst_in = 1'b0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_exc", 32'(out_exc), 0);
    check("rst_st_done", 32'(st_done), 0);
    check("rst_full", 32'(full), 0);
    check("rst_req_valid", 32'(mem_req_valid), 0);
    check("rst_out_value", out_value, 0);
    check("rst_count", 32'(dut.count), 0);

    // Single loads: push, request next cycle, response, result one cycle later.
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].typ, vecs[i].rob, vecs[i].r1, 32'h0, vecs[i].off, 1'b0, '0);
      check($sformatf("vec%0d_req_valid", i), 32'(mem_req_valid), 1);
      check($sformatf("vec%0d_addr", i), mem_req_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_len", i), 32'(mem_req_len), 32'(vecs[i].exp_len));
      check($sformatf("vec%0d_wr", i), 32'(mem_req_wr), 0);
      complete($sformatf("vec%0d", i), vecs[i].resp);
      check($sformatf("vec%0d_rob", i), 32'(out_rob), 32'(vecs[i].rob));
      check($sformatf("vec%0d_exc", i), 32'(out_exc), 0);
    end
    step();
    check("pulse_cleared", 32'(out_valid), 0);

    // Store waits for commit match.
    cm_valid = 1'b1; cm_rob = 4'd2;
    push(4'hA, 4'd3, 32'h0000_0200, 32'h0000_0055, 12'h000, 1'b0, '0);
    check("st_uncommitted", 32'(mem_req_valid), 0);
    step();
    check("st_uncommitted2", 32'(mem_req_valid), 0);
    cm_rob = 4'd3; #1;
    check("st_req_valid", 32'(mem_req_valid), 1);
    check("st_req_wr", 32'(mem_req_wr), 1);
    check("st_req_data", mem_req_data, 32'h55);
    check("st_req_addr", mem_req_addr, 32'h200);
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; step(); mem_resp_valid = 1'b0;
    check("st_done_pulse", 32'(st_done), 1);
    check("st_no_out_valid", 32'(out_valid), 0);
    step();
    check("st_done_cleared", 32'(st_done), 0);
    cm_valid = 1'b0;

    // Fill to DEPTH with uncommitted stores.
    for (int i = 0; i < DEPTH; i++) begin
      push(4'hA, RB'(i), 32'h300, 32'h0, 12'h0, 1'b0, '0);
      if (i == DEPTH - 2) check("full_before_last", 32'(full), 0);
    end
    check("full_after_last", 32'(full), 1);
    cm_valid = 1'b1; cm_rob = 4'd0; #1;
    check("full_head_req", 32'(mem_req_valid), 1);
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    cm_valid = 1'b0;
    mem_resp_valid = 1'b1;
    push(4'hA, 4'd8, 32'h300, 32'h0, 12'h0, 1'b0, '0);
    mem_resp_valid = 1'b0;
    check("full_pop_push", 32'(full), 1);
    check("full_pop_push_count", 32'(dut.count), DEPTH);
    check("full_pop_push_st_done", 32'(st_done), 1);
    // Flush in IDLE with a simultaneous push: everything cleared, push dropped.
    flush = 1'b1; in_valid = 1'b1; step(); flush = 1'b0; in_valid = 1'b0;
    check("flush_idle_count", 32'(dut.count), 0);
    check("flush_idle_full", 32'(full), 0);

    // Wake-up via channel 1 after push.
    push(4'h2, 4'd6, 32'hDEAD_0000, 32'h0, 12'h000, 1'b1, 4'd5);
    check("dep_blocked", 32'(mem_req_valid), 0);
    wb_valid = 2'b11; wb_idx = {4'd5, 4'd7}; wb_value = {32'h20, 32'h99};
    step();
    wb_valid = '0;
    check("dep_woken", 32'(mem_req_valid), 1);
    check("dep_addr", mem_req_addr, 32'h20);
    complete("dep", 32'h11);
    // Two channels match: lowest wins.
    push(4'h2, 4'd7, 32'h0, 32'h0, 12'h000, 1'b1, 4'd9);
    wb_valid = 2'b11; wb_idx = {4'd9, 4'd9}; wb_value = {32'h80, 32'h40};
    step();
    wb_valid = '0;
    check("dep_lowk_addr", mem_req_addr, 32'h40);
    complete("dep_lowk", 32'h22);
    // Match on the push cycle itself.
    wb_valid = 2'b10; wb_idx = {4'd10, 4'd0}; wb_value = {32'h300, 32'h0};
    push(4'h2, 4'd8, 32'h0, 32'h0, 12'h004, 1'b1, 4'd10);
    wb_valid = '0;
    check("dep_push_valid", 32'(mem_req_valid), 1);
    check("dep_push_addr", mem_req_addr, 32'h304);
    complete("dep_push", 32'h33);

    // Load in WAIT + flush: DRAIN swallows the response.
    push(4'h2, 4'd1, 32'h400, 32'h0, 12'h0, 1'b0, '0);
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    check("ldflush_count", 32'(dut.count), 0);
    check("ldflush_state", 32'(dut.state), 2);
    mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD; step(); mem_resp_valid = 1'b0;
    check("ldflush_no_out", 32'(out_valid), 0);
    check("ldflush_idle", 32'(dut.state), 0);

    // Store in WAIT + flush: store completes, younger load dropped.
    cm_valid = 1'b1; cm_rob = 4'd4;
    push(4'hA, 4'd4, 32'h500, 32'h77, 12'h0, 1'b0, '0);
    push(4'h2, 4'd5, 32'h600, 32'h0, 12'h0, 1'b0, '0);
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    check("stflush_count1", 32'(dut.count), 1);
    check("stflush_wait", 32'(dut.state), 1);
    mem_resp_valid = 1'b1; step(); mem_resp_valid = 1'b0;
    check("stflush_st_done", 32'(st_done), 1);
    check("stflush_count0", 32'(dut.count), 0);
    step();
    check("stflush_no_req", 32'(mem_req_valid), 0);
    check("stflush_no_out", 32'(out_valid), 0);
    cm_valid = 1'b0;

    // Global stall freezes state and masks the request.
    push(4'h2, 4'd2, 32'h700, 32'h0, 12'h0, 1'b0, '0);
    rdy_in = 1'b0; #1;
    check("stall_no_req", 32'(mem_req_valid), 0);
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    check("stall_count", 32'(dut.count), 1);
    check("stall_state", 32'(dut.state), 0);
    rdy_in = 1'b1; #1;
    check("stall_release_req", 32'(mem_req_valid), 1);
    complete("stall", 32'h44);

`ifdef LSQ_MISALIGN_EN
    push(4'h1, 4'd9, 32'h101, 32'h0, 12'h0, 1'b0, '0);
    check("mis_no_req", 32'(mem_req_valid), 0);
    step();
    check("mis_out_valid", 32'(out_valid), 1);
    check("mis_out_exc", 32'(out_exc), 1);
    check("mis_out_value", out_value, 32'h101);
    check("mis_count", 32'(dut.count), 0);
`else
    push(4'h1, 4'd9, 32'h101, 32'h0, 12'h0, 1'b0, '0);
    check("mis_off_req", 32'(mem_req_valid), 1);
    check("mis_off_addr", mem_req_addr, 32'h101);
    complete("mis_off", 32'h55);
    check("mis_off_exc", 32'(out_exc), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
